// File: rtl/stopwatch_display.sv
// stopwatch_display: time-multiplexed mm:ss driver for a 4-digit common-anode 7-segment display.
// The mins/secs snapshot is taken once per frame and converted to BCD by a small
// shift-add-3 sequencer, so the digits only change between frames (no tearing).
// Optional blinking of the field being adjusted: define STOPWATCH_DISP_BLINK_EN.
module stopwatch_display #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       currclk,
  input  logic       rst,
  input  logic [1:0] state,
  input  logic [5:0] mins,
  input  logic [5:0] secs,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [15:0] ScanLast = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DigDash  = 4'hA;
  localparam logic [6:0]  SegBlank = 7'h7F;

  typedef enum logic [1:0] {StIdle, StConv, StLoad} conv_state_e;

  conv_state_e r_cs, w_ns;

  logic [15:0] r_scan_cnt;
  logic [1:0]  r_digit_idx;
  logic        w_scan_wrap;
  logic        w_frame_end;
  logic        w_snap_take;
  logic [5:0]  r_snap_min;
  logic [5:0]  r_snap_sec;
  // {tens, ones, binary}: binary bits are shifted up into the BCD nibbles
  logic [13:0] r_min_sr;
  logic [13:0] r_sec_sr;
  logic [2:0]  r_conv_cnt;
  logic [3:0]  r_dig3, r_dig2, r_dig1, r_dig0;
  logic [3:0]  w_cur_dig;
  logic        w_blank_req;
  logic        w_hidden;
  logic        w_blank;

  // One double-dabble step: add 3 to any nibble >= 5, then shift left.
  function automatic logic [13:0] dd_step(input logic [13:0] v);
    logic [13:0] t;
    t = v;
    if (t[9:6] >= 4'd5) t[9:6] = t[9:6] + 4'd3;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    return {t[12:0], 1'b0};
  endfunction

  // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign w_scan_wrap = (r_scan_cnt == ScanLast);
  assign w_frame_end = w_scan_wrap && (r_digit_idx == 2'd3);
  // A frame end during a conversion is dropped rather than queued.
  assign w_snap_take = w_frame_end && (r_cs == StIdle);

  // Scan counter and digit index.
  always_ff @(posedge currclk or posedge rst) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= '0;
    end else if (w_scan_wrap) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= r_digit_idx + 2'd1;
    end else begin
      r_scan_cnt  <= r_scan_cnt + 16'd1;
    end
  end

  // Conversion FSM state register.
  always_ff @(posedge currclk or posedge rst) begin
    if (rst) r_cs <= StIdle;
    else     r_cs <= w_ns;
  end

  // Conversion FSM next state.
  always_comb begin
    w_ns = r_cs;
    unique case (r_cs)
      StIdle:  if (w_snap_take) w_ns = StConv;
      StConv:  if (r_conv_cnt == 3'd5) w_ns = StLoad;
      StLoad:  w_ns = StIdle;
      default: w_ns = StIdle;
    endcase
  end

  // Snapshot, BCD shifting and the digit registers (written only in StLoad).
  always_ff @(posedge currclk or posedge rst) begin
    if (rst) begin
      r_snap_min <= '0;
      r_snap_sec <= '0;
      r_min_sr   <= '0;
      r_sec_sr   <= '0;
      r_conv_cnt <= '0;
      r_dig3     <= '0;
      r_dig2     <= '0;
      r_dig1     <= '0;
      r_dig0     <= '0;
    end else begin
      unique case (r_cs)
        StIdle: begin
          if (w_snap_take) begin
            r_snap_min <= mins;
            r_snap_sec <= secs;
            r_min_sr   <= {8'd0, mins};
            r_sec_sr   <= {8'd0, secs};
            r_conv_cnt <= '0;
          end
        end
        StConv: begin
          r_min_sr   <= dd_step(r_min_sr);
          r_sec_sr   <= dd_step(r_sec_sr);
          r_conv_cnt <= r_conv_cnt + 3'd1;
        end
        StLoad: begin
          r_dig3 <= (r_snap_min > 6'd59) ? DigDash : r_min_sr[13:10];
          r_dig2 <= (r_snap_min > 6'd59) ? DigDash : r_min_sr[9:6];
          r_dig1 <= (r_snap_sec > 6'd59) ? DigDash : r_sec_sr[13:10];
          r_dig0 <= (r_snap_sec > 6'd59) ? DigDash : r_sec_sr[9:6];
        end
        default: ;
      endcase
    end
  end

  // Digit selected by the scan index.
  always_comb begin
    w_cur_dig = r_dig0;
    unique case (r_digit_idx)
      2'd0: w_cur_dig = r_dig0;
      2'd1: w_cur_dig = r_dig1;
      2'd2: w_cur_dig = r_dig2;
      2'd3: w_cur_dig = r_dig3;
      default: w_cur_dig = r_dig0;
    endcase
  end

  // Digits belonging to the field under adjustment.
  assign w_blank_req = ((state == 2'b01) && r_digit_idx[1]) ||
                       ((state == 2'b10) && !r_digit_idx[1]);

`ifdef STOPWATCH_DISP_BLINK_EN
  localparam logic [7:0] BlinkLast = 8'(BLINK_FRAMES - 1);

  logic [7:0] r_blink_cnt;
  logic       r_hidden;
  logic [1:0] r_state_prev;

  // Frame counter toggles the blink phase; a mode change restarts it visible.
  always_ff @(posedge currclk or posedge rst) begin
    if (rst) begin
      r_blink_cnt  <= '0;
      r_hidden     <= 1'b0;
      r_state_prev <= 2'b00;
    end else begin
      r_state_prev <= state;
      if (state != r_state_prev) begin
        r_blink_cnt <= '0;
        r_hidden    <= 1'b0;
      end else if (w_frame_end) begin
        if (r_blink_cnt == BlinkLast) begin
          r_blink_cnt <= '0;
          r_hidden    <= ~r_hidden;
        end else begin
          r_blink_cnt <= r_blink_cnt + 8'd1;
        end
      end
    end
  end

  assign w_hidden = r_hidden;
`else
  assign w_hidden = 1'b0;
`endif

  assign w_blank = w_hidden && w_blank_req;

  // Registered display outputs; dp is the min:sec colon on digit 2.
  always_ff @(posedge currclk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SegBlank;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << r_digit_idx);
      seg <= w_blank ? SegBlank : seg_decode(w_cur_dig);
      dp  <= w_blank | (r_digit_idx != 2'd2);
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display: directed, table-driven bench for stopwatch_display (SCAN_DIV=8).
// Builds with or without STOPWATCH_DISP_BLINK_EN; the blink expectations follow the macro.
module tb_stopwatch_display;

  localparam int unsigned ScanDiv     = 8;
  localparam int unsigned BlinkFrames = 2;
`ifdef STOPWATCH_DISP_BLINK_EN
  localparam bit BlinkEn = 1'b1;
`else
  localparam bit BlinkEn = 1'b0;
`endif

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'h7F;

  typedef struct {
    logic [5:0] m;
    logic [5:0] s;
    logic [6:0] e3;
    logic [6:0] e2;
    logic [6:0] e1;
    logic [6:0] e0;
  } vec_t;

  logic       currclk;
  logic       rst;
  logic [1:0] state;
  logic [5:0] mins;
  logic [5:0] secs;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int         checks;
  int         errors;
  logic [3:0] prev_an;
  logic [6:0] cap_seg [4];
  vec_t       vecs [7];

  stopwatch_display #(
    .SCAN_DIV    (ScanDiv),
    .BLINK_FRAMES(BlinkFrames)
  ) dut (
    .currclk(currclk),
    .rst    (rst),
    .state  (state),
    .mins   (mins),
    .secs   (secs),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  initial currclk = 1'b0;
  always #5 currclk = ~currclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    prev_an = an;
    @(posedge currclk);
    #1;
  endtask

  // Reset released 1 time unit after an edge, so the next edge is edge 1.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Edges 1..39 after release must all show "0"; edge 40 shows the first loaded digit 0.
  task automatic zero_window(input string name, input logic [6:0] exp40);
    int bad_seg;
    int bad_an;
    logic [3:0] ea;
    bad_seg = 0;
    bad_an  = 0;
    for (int k = 1; k <= 39; k++) begin
      tick();
      ea = 4'b0001 << (((k - 1) / 8) % 4);
      ea = ~ea;
      if (an !== ea) bad_an++;
      if (seg !== S0) bad_seg++;
    end
    check({name, "_zero_cycles_bad"}, 32'(bad_seg), 32'd0);
    check({name, "_an_cycles_bad"}, 32'(bad_an), 32'd0);
    tick();
    check({name, "_first_load_seg"}, 32'(seg), 32'(exp40));
    check({name, "_first_load_an"}, 32'(an), 32'(4'b1110));
  endtask

  task automatic find_start(input string name);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 80 && !found; n++) begin
      tick();
      if (an == 4'b1110 && prev_an == 4'b0111) found = 1'b1;
    end
    check({name, "_frame_start"}, 32'(found), 32'd1);
  endtask

  // Capture one frame; each digit is sampled on its last enabled cycle.
  task automatic capture(input string name);
    int bad_an;
    int bad_dp;
    logic [3:0] ea;
    logic       edp;
    find_start(name);
    bad_an = 0;
    bad_dp = 0;
    for (int o = 0; o < 32; o++) begin
      if (o > 0) tick();
      ea  = 4'b0001 << (o / 8);
      ea  = ~ea;
      edp = ((o / 8) == 2) ? 1'b0 : 1'b1;
      if (an !== ea) bad_an++;
      if (dp !== edp) bad_dp++;
      if ((o % 8) == 7) cap_seg[o / 8] = seg;
    end
    check({name, "_an_cycles_bad"}, 32'(bad_an), 32'd0);
    check({name, "_dp_cycles_bad"}, 32'(bad_dp), 32'd0);
  endtask

  task automatic check_digits(input string name, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
    check({name, "_d3"}, 32'(cap_seg[3]), 32'(e3));
    check({name, "_d2"}, 32'(cap_seg[2]), 32'(e2));
    check({name, "_d1"}, 32'(cap_seg[1]), 32'(e1));
    check({name, "_d0"}, 32'(cap_seg[0]), 32'(e0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int bad_s;
    int bad_d;
    int f;
    int idx;
    logic       hid;
    logic [6:0] es;
    logic       ed;
    logic [6:0] dig_tab [4];

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    state  = 2'b00;
    mins   = 6'd0;
    secs   = 6'd0;
    prev_an = 4'b1111;

    vecs[0] = '{m: 6'd12, s: 6'd34, e3: S1, e2: S2, e1: S3, e0: S4};
    vecs[1] = '{m: 6'd60, s: 6'd59, e3: SD, e2: SD, e1: S5, e0: S9};
    vecs[2] = '{m: 6'd0,  s: 6'd0,  e3: S0, e2: S0, e1: S0, e0: S0};
    vecs[3] = '{m: 6'd59, s: 6'd60, e3: S5, e2: S9, e1: SD, e0: SD};
    vecs[4] = '{m: 6'd63, s: 6'd1,  e3: SD, e2: SD, e1: S0, e0: S1};
    vecs[5] = '{m: 6'd45, s: 6'd7,  e3: S4, e2: S5, e1: S0, e0: S7};
    vecs[6] = '{m: 6'd28, s: 6'd6,  e3: S2, e2: S8, e1: S0, e0: S6};

    // Reset state, then 00:00 until the first load with 12:34 on the inputs.
    mins = 6'd12;
    secs = 6'd34;
    tick();
    check("reset_an", 32'(an), 32'(4'b1111));
    check("reset_seg", 32'(seg), 32'(SB));
    check("reset_dp", 32'(dp), 32'd1);
    do_reset();
    zero_window("first", S4);

    // Table of values, including out-of-range dashes.
    for (int i = 0; i < 7; i++) begin
      mins = vecs[i].m;
      secs = vecs[i].s;
      repeat (4) tick();
      capture($sformatf("vec%0d", i));
      check_digits($sformatf("vec%0d", i), vecs[i].e3, vecs[i].e2, vecs[i].e1, vecs[i].e0);
    end

    // Mid-frame change: old digits hold until the load after the next frame end.
    mins = 6'd12;
    secs = 6'd34;
    repeat (4) tick();
    capture("tear_pre");
    repeat (10) tick();
    secs = 6'd35;
    find_start("tear");
    bad_s = 0;
    for (int o = 0; o < 7; o++) begin
      if (o > 0) tick();
      if (seg !== S4) bad_s++;
    end
    check("tear_old_cycles_bad", 32'(bad_s), 32'd0);
    tick();
    check("tear_new_d0", 32'(seg), 32'(S5));
    capture("tear_post");
    check_digits("tear_post", S1, S2, S3, S5);

    // Asynchronous reset pulse mid-scan.
    repeat (5) tick();
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_an", 32'(an), 32'(4'b1111));
    check("async_rst_seg", 32'(seg), 32'(SB));
    check("async_rst_dp", 32'(dp), 32'd1);
    @(posedge currclk);
    #1;
    rst = 1'b0;
    zero_window("rst_mid", S5);
    capture("rst_mid");
    check_digits("rst_mid", S1, S2, S3, S5);

    // Reset during the third conversion cycle: nothing partial may be loaded.
    mins = 6'd45;
    secs = 6'd17;
    do_reset();
    repeat (34) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    zero_window("abort", S7);
    capture("abort");
    check_digits("abort", S4, S5, S1, S7);

    // Minute-adjust blinking (visible 2 frames, hidden 2 frames when enabled).
    state = 2'b01;
    mins  = 6'd12;
    secs  = 6'd34;
    dig_tab[0] = S4;
    dig_tab[1] = S3;
    dig_tab[2] = S2;
    dig_tab[3] = S1;
    do_reset();
    bad_s = 0;
    bad_d = 0;
    for (int k = 1; k <= 84; k++) begin
      tick();
      f   = (k - 1) / 32;
      idx = ((k - 1) / 8) % 4;
      hid = BlinkEn && (f == 2 || f == 3) && (idx >= 2);
      es  = (k <= 39) ? S0 : dig_tab[idx];
      ed  = (idx == 2) ? 1'b0 : 1'b1;
      if (hid) begin
        es = SB;
        ed = 1'b1;
      end
      if (seg !== es) bad_s++;
      if (dp !== ed) bad_d++;
    end
    check("blink_seg_cycles_bad", 32'(bad_s), 32'd0);
    check("blink_dp_cycles_bad", 32'(bad_d), 32'd0);
    state = 2'b00;
    tick();
    check("blink_run_visible_seg", 32'(seg), 32'(S2));
    check("blink_run_visible_dp", 32'(dp), 32'd0);
    state = 2'b01;
    tick();
    check("blink_phase_restart_seg", 32'(seg), 32'(S2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning currclk cycles per digit slot (legal range 8 to 65535).
REQ-002 SHALL have parameter BLINK_FRAMES, default 64, meaning full 4-digit frames per blink half-period (legal range 1 to 255).
REQ-003 SHALL have port currclk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port state  input  2  stopwatch mode: 00 run, 01 minute adjust, 10 second adjust, 11 pause.
REQ-006 SHALL have port mins  input  6  binary minutes from the counter.
REQ-007 SHALL have port secs  input  6  binary seconds from the counter.
REQ-008 SHALL have port an  output  4  digit enables, active-low; an[3]=min tens, an[2]=min ones, an[1]=sec tens, an[0]=sec ones.
REQ-009 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-011 SHALL use a scan counter 0..SCAN_DIV-1; at terminal count it SHALL wrap to 0 and advance digit index 0->1->2->3->0.
REQ-012 SHALL drive an, seg and dp as registers, one cycle after the digit index and the digit registers.
REQ-013 SHALL assert exactly one an bit per cycle after reset release: an = ~(1<<digit index).
REQ-014 SHALL mark frame end on the 3->0 index wrap, and on that edge SHALL latch mins and secs into snapshot registers.
REQ-015 SHALL convert the snapshot to BCD with a sequential shift-add-3 FSM: IDLE -> CONV (6 cycles, mins and secs in parallel) -> LOAD (1 cycle) -> IDLE.
REQ-016 SHALL update the four digit registers on the LOAD edge, 7 cycles after the snapshot edge; digits SHALL NOT change at any other time (no tearing).
REQ-017 SHALL encode each value above 59 as two dash digits (seg=7'b0111111) and SHALL NOT show its BCD value.
REQ-018 SHALL use standard hex patterns for 0-9 (for example 0=7'b1000000, 5=7'b0010010, 9=7'b0010000).
REQ-019 SHALL drive dp low only while digit 2 is enabled, as the min:sec separator.
REQ-020 SHALL ignore a frame-end snapshot request arriving while the FSM is not IDLE; SCAN_DIV>=8 makes this unreachable.
REQ-021 SHALL take mins, secs and state as synchronous to currclk, with no extra synchronizers.

Reset
REQ-022 On rst, SHALL set: an=4'b1111, seg=7'h7F, dp=1, scan counter=0, digit index=0, snapshots=0, digit registers=0, FSM=IDLE, blink counter=0, blink phase=visible.
REQ-023 SHALL show 00:00 from reset release until the first LOAD.
REQ-024 Reset asserted mid-CONV SHALL abort the conversion; the digit registers SHALL stay 0 and no partial value SHALL be loaded.

Configuration
REQ-025 Macro STOPWATCH_DISP_BLINK_EN, when defined, SHALL include a frame counter that toggles blink phase every BLINK_FRAMES frames.
REQ-026 With the macro defined, during the hidden phase: state=01 SHALL blank digits 3 and 2 (seg=7'h7F, dp=1); state=10 SHALL blank digits 1 and 0; states 00 and 11 SHALL never blank.
REQ-027 With the macro defined, any change of state SHALL reset blink phase to visible and the frame counter to 0 on the next edge.
REQ-028 Without the macro, SHALL have no blink logic and no blanking; all other behaviour SHALL be identical.

Verification
REQ-029 SHALL cover: rst pulse mid-scan -> an=1111, seg=7F immediately; after release, index 0 digit shows "0" (seg=7'b1000000), frame shows 00:00.
REQ-030 SHALL cover: SCAN_DIV=8, mins=12, secs=34 -> next frame digits 1,2,3,4; dp low only when an=1011; each an bit low for exactly 8 cycles.
REQ-031 SHALL cover: change secs from 34 to 35 mid-frame -> displayed digits unchanged until 7 cycles after the next frame end, then 3,5.
REQ-032 SHALL cover: mins=60, secs=59 -> digits 3 and 2 show dash 7'b0111111; digits 1 and 0 show 5 and 9.
REQ-033 SHALL cover, with STOPWATCH_DISP_BLINK_EN and BLINK_FRAMES=2, state=01: minute digits visible 2 frames then blanked 2 frames; seconds are never blanked; switching to 00 makes all digits visible at once.
REQ-034 SHALL cover: rst asserted on the 3rd CONV cycle with mins=45 -> after release, digits stay 0 until a full new conversion completes.
